ps2_mouse_packet_assembler: RTL and testbench
=============================================

// Module: ps2_mouse_packet_assembler
// PURPOSE
//  Producer side of the mouse-state handshake: assembles 3-byte PS/2 stream-mode packets
//  into buttons + 9-bit two's-complement X/Y deltas. Presents them on data_ready/read.
//  Sits between the PS/2 byte receiver and ps2_mouse_state2. Handles resync, overflow
//  and inter-byte timeout.
// PARAMETERS
//  TIMEOUT_CYCLES  1_000_000  max clk cycles between bytes of one packet before discard
// PORTS
//  clk            in   1  clock
//  reset          in   1  synchronous, active-high
//  byte_in        in   8  received byte, valid when byte_valid=1
//  byte_valid     in   1  one-cycle strobe per received byte
//  byte_error     in   1  one-cycle strobe: parity/framing error on current byte
//  read           in   1  consumer acknowledge, one cycle, only while data_ready=1
//  left_button    out  1  packet byte0[0]
//  right_button   out  1  packet byte0[1]
//  middle_button  out  1  packet byte0[2]
//  x_increment    out  9  {byte0[4], byte1}, saturated on overflow
//  y_increment    out  9  {byte0[5], byte2}, saturated on overflow (PS/2 +Y = up)
//  data_ready     out  1  packet held on outputs, awaiting read
//  sync_error     out  1  one-cycle pulse: byte discarded, error or timeout
//  overrun        out  1  one-cycle pulse: completed packet lost (macro off only)
// BEHAVIOUR
//  - Reset: all outputs 0; state WAIT_B0; timeout counter 0. Reset mid-packet discards it.
//  - FSM on byte_valid: WAIT_B0 -> WAIT_B1 -> WAIT_B2 -> WAIT_B0; packet completes on byte 2.
//  - WAIT_B0: byte with bit3=0 is discarded; sync_error pulses; state stays WAIT_B0.
//  - byte_error in any state: partial packet discarded; go WAIT_B0; sync_error pulses.
//    byte_error has priority over byte_valid in the same cycle.
//  - Timeout: in WAIT_B1/WAIT_B2, counter increments each cycle without byte_valid and
//    clears on byte_valid. At TIMEOUT_CYCLES-1: go WAIT_B0; sync_error pulses.
//    Counter width is $clog2(TIMEOUT_CYCLES).
//  - Overflow: byte0[6] (X) / byte0[7] (Y) set -> delta forced to 9'h0FF if sign=0,
//    9'h100 if sign=1.
//  - Output load: the completed packet loads the output registers on the cycle after
//    byte 2, if data_ready=0 or read=1. data_ready<=1 on the same edge.
//  - Handshake:
//    - Outputs are stable for the whole time data_ready=1.
//    - read=1 clears data_ready on that edge unless a new packet loads on the same edge.
//    - If it does, data_ready stays 1 and the outputs carry the new values.
//    - read while data_ready=0 is ignored.
//  - Latency: byte 2 strobe at cycle N -> data_ready=1 at cycle N+1.
// CONFIGURATION
//  MOUSE_ACCUMULATE_EN defined:
//   - A packet completing while data_ready=1 and read=0 is merged into a pending
//     accumulator: per-axis saturating add clamped to [-256,+255]; buttons take latest.
//   - On the edge read=1 is seen, the pending accumulator (if any) loads the outputs,
//     data_ready stays 1 and pending clears.
//   - overrun is tied 0.
//  Not defined: that packet is dropped and overrun pulses; outputs are unchanged.
// STRUCTURE
//  - Shared include ps2_mouse_constants.v holds:
//    - byte0 bit positions (BTN_L=0, BTN_R=1, BTN_M=2, SYNC=3, XS=4, YS=5, XO=6, YO=7);
//    - DELTA_MAX=9'h0FF and DELTA_MIN=9'h100;
//    - FSM state encodings.
//  - TRUE/FALSE come from constant.v.
//  - Sub-module ps2_mouse_delta_saturate: combinational 9-bit signed saturating add.
//    Used only under MOUSE_ACCUMULATE_EN; instantiate it once per axis.
// TESTING
//  1. Bytes 0x09,0x05,0xFB -> L=1, x=9'h005, y=9'h0FB, data_ready=1 one cycle after 0xFB;
//     read -> data_ready=0 next cycle.
//  2. Byte 0x01 in WAIT_B0 -> sync_error pulse, no state change; then 0x38,0xF0,0x10
//     -> x=9'h1F0, y=9'h110.
//  3. 0x48,0x12,0x00 (X overflow, +) -> x=9'h0FF; 0x58,0x12,0x00 -> x=9'h100.
//  4. 0x08 then 0x01, then idle TIMEOUT_CYCLES cycles -> sync_error pulse; next bytes
//     0x08,0x02,0x03 -> x=2, y=3.
//  5. Second packet 0x08,0x03,0x00 completes while first (x=2) unread:
//     - macro off: overrun pulse, x stays 2;
//     - macro on, read later: data_ready stays 1, x=9'h003.
//  6. byte_error after byte1, reset asserted mid-packet, and read coincident with load
//     -> discard with sync_error, all outputs 0 after reset, data_ready held 1 with
//     new values.

Source files
------------

// File: rtl/ps2_mouse_packet_assembler_pkg.sv
// rtl/ps2_mouse_packet_assembler_pkg.sv - shared constants, types and delta decode for the PS/2 mouse packet assembler
package ps2_mouse_packet_assembler_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // byte0 bit positions
    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_M = 2;
    localparam int SYNC  = 3;
    localparam int XS    = 4;
    localparam int YS    = 5;
    localparam int XO    = 6;
    localparam int YO    = 7;

    localparam logic [8:0] DELTA_MAX = 9'h0FF;
    localparam logic [8:0] DELTA_MIN = 9'h100;

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2
    } state_t;

    typedef struct packed {
        logic       left;
        logic       right;
        logic       middle;
        logic [8:0] x;
        logic [8:0] y;
    } mouse_pkt_t;

    // An overflowed axis is reported as the extreme value in the direction of its sign.
    function automatic logic [8:0] decode_delta(input logic sign, input logic ovf,
                                                input logic [7:0] mag);
        if (ovf)
            return sign ? DELTA_MIN : DELTA_MAX;
        return {sign, mag};
    endfunction

endpackage

// File: rtl/ps2_mouse_packet_assembler_if.sv
// rtl/ps2_mouse_packet_assembler_if.sv - mouse-state handshake between the packet assembler and its consumer
// master: drives buttons, x/y increments and data_ready; samples read.
// slave : samples the packet fields; drives read (one-cycle acknowledge).
interface ps2_mouse_packet_assembler_if;
    logic       left_button;
    logic       right_button;
    logic       middle_button;
    logic [8:0] x_increment;
    logic [8:0] y_increment;
    logic       data_ready;
    logic       read;

    modport master (
        output left_button, right_button, middle_button,
        output x_increment, y_increment, data_ready,
        input  read
    );

    modport slave (
        input  left_button, right_button, middle_button,
        input  x_increment, y_increment, data_ready,
        output read
    );
endinterface

// File: rtl/ps2_mouse_delta_saturate.sv
// rtl/ps2_mouse_delta_saturate.sv - combinational 9-bit signed add clamped to [-256,+255]
// Ports: a, b (9-bit two's complement addends), sum (clamped result).
module ps2_mouse_delta_saturate
    import ps2_mouse_packet_assembler_pkg::*;
(
    input  logic [8:0] a,
    input  logic [8:0] b,
    output logic [8:0] sum
);
    logic [9:0] wide;

    assign wide = {a[8], a} + {b[8], b};

    // Top two bits disagree only when the true result left the 9-bit range.
    always_comb begin
        sum = wide[8:0];
        if (wide[9] != wide[8])
            sum = wide[9] ? DELTA_MIN : DELTA_MAX;
    end
endmodule

// File: rtl/ps2_mouse_packet_assembler.sv
// rtl/ps2_mouse_packet_assembler.sv - assembles 3-byte PS/2 stream packets into buttons + 9-bit X/Y deltas
// Ports: clk, reset (sync, active-high); byte_in/byte_valid/byte_error from the PS/2 byte
// receiver; mouse (master modport: buttons, x/y increments, data_ready, read);
// sync_error (pulse: byte or partial packet discarded); overrun (pulse: completed packet lost).
// Macro MOUSE_ACCUMULATE_EN: packets arriving while the output is unread are merged into a
// pending accumulator instead of being dropped; overrun is then always 0.
module ps2_mouse_packet_assembler
    import ps2_mouse_packet_assembler_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    byte_in,
    input  logic                          byte_valid,
    input  logic                          byte_error,
    ps2_mouse_packet_assembler_if.master  mouse,
    output logic                          sync_error,
    output logic                          overrun
);
    localparam int              CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       b0_q, b0_d, b1_q, b1_d;
    mouse_pkt_t       out_q, out_d;
    logic             ready_q, ready_d;
    logic             sync_error_q, sync_error_d;
    logic             overrun_q, overrun_d;
    logic             discard, pkt_done;
    mouse_pkt_t       new_pkt;

    // Byte 2 is still on byte_in when the packet completes, so y comes straight from it.
    always_comb begin
        new_pkt.left   = b0_q[BTN_L];
        new_pkt.right  = b0_q[BTN_R];
        new_pkt.middle = b0_q[BTN_M];
        new_pkt.x      = decode_delta(b0_q[XS], b0_q[XO], b1_q);
        new_pkt.y      = decode_delta(b0_q[YS], b0_q[YO], byte_in);
    end

`ifdef MOUSE_ACCUMULATE_EN
    mouse_pkt_t pend_q, pend_d, merged;
    logic       pend_valid_q, pend_valid_d;
    logic [8:0] base_x, base_y, sum_x, sum_y;

    // With nothing pending the base is zero, so the merge reduces to the new packet.
    assign base_x = pend_valid_q ? pend_q.x : 9'h000;
    assign base_y = pend_valid_q ? pend_q.y : 9'h000;

    ps2_mouse_delta_saturate u_sat_x (.a(base_x), .b(new_pkt.x), .sum(sum_x));
    ps2_mouse_delta_saturate u_sat_y (.a(base_y), .b(new_pkt.y), .sum(sum_y));

    always_comb begin
        merged   = new_pkt;
        merged.x = sum_x;
        merged.y = sum_y;
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= WAIT_B0;
            cnt_q        <= '0;
            b0_q         <= '0;
            b1_q         <= '0;
            out_q        <= '0;
            ready_q      <= FALSE;
            sync_error_q <= FALSE;
            overrun_q    <= FALSE;
`ifdef MOUSE_ACCUMULATE_EN
            pend_q       <= '0;
            pend_valid_q <= FALSE;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            b0_q         <= b0_d;
            b1_q         <= b1_d;
            out_q        <= out_d;
            ready_q      <= ready_d;
            sync_error_q <= sync_error_d;
            overrun_q    <= overrun_d;
`ifdef MOUSE_ACCUMULATE_EN
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
`endif
        end
    end

    // Next-state logic, inter-byte timeout and packet-complete/discard events
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        b0_d     = b0_q;
        b1_d     = b1_q;
        discard  = FALSE;
        pkt_done = FALSE;
        if (byte_error) begin
            state_d = WAIT_B0;
            cnt_d   = '0;
            discard = TRUE;
        end else begin
            case (state_q)
                WAIT_B0: begin
                    cnt_d = '0;
                    if (byte_valid) begin
                        if (byte_in[SYNC]) begin
                            b0_d    = byte_in;
                            state_d = WAIT_B1;
                        end else begin
                            discard = TRUE;
                        end
                    end
                end
                WAIT_B1, WAIT_B2: begin
                    if (byte_valid) begin
                        cnt_d = '0;
                        if (state_q == WAIT_B1) begin
                            b1_d    = byte_in;
                            state_d = WAIT_B2;
                        end else begin
                            pkt_done = TRUE;
                            state_d  = WAIT_B0;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = WAIT_B0;
                        discard = TRUE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = WAIT_B0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output register loading and read handshake
    always_comb begin
        out_d        = out_q;
        ready_d      = ready_q;
        sync_error_d = discard;
        overrun_d    = FALSE;
`ifdef MOUSE_ACCUMULATE_EN
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        if (ready_q && mouse.read) begin
            if (pend_valid_q) begin
                out_d        = pkt_done ? merged : pend_q;
                pend_valid_d = FALSE;
            end else if (pkt_done) begin
                out_d = new_pkt;
            end else begin
                ready_d = FALSE;
            end
        end else if (ready_q && pkt_done) begin
            pend_d       = merged;
            pend_valid_d = TRUE;
        end else if (pkt_done) begin
            out_d   = new_pkt;
            ready_d = TRUE;
        end
`else
        if (pkt_done && (!ready_q || mouse.read)) begin
            out_d   = new_pkt;
            ready_d = TRUE;
        end else if (pkt_done) begin
            overrun_d = TRUE;
        end else if (ready_q && mouse.read) begin
            ready_d = FALSE;
        end
`endif
    end

    assign mouse.left_button   = out_q.left;
    assign mouse.right_button  = out_q.right;
    assign mouse.middle_button = out_q.middle;
    assign mouse.x_increment   = out_q.x;
    assign mouse.y_increment   = out_q.y;
    assign mouse.data_ready    = ready_q;
    assign sync_error          = sync_error_q;
    assign overrun             = overrun_q;
endmodule

// File: tb/tb_ps2_mouse_packet_assembler.sv
// tb/tb_ps2_mouse_packet_assembler.sv - self-checking bench for ps2_mouse_packet_assembler
module tb_ps2_mouse_packet_assembler;
    localparam int T = 40;

    typedef struct {
        logic       l, r, m;
        logic [8:0] x, y;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_error;
    logic       sync_error;
    logic       overrun;

    ps2_mouse_packet_assembler_if mouse_if ();

    ps2_mouse_packet_assembler #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .reset      (reset),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_error (byte_error),
        .mouse      (mouse_if.master),
        .sync_error (sync_error),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [8:0] model_delta(input logic sign, input logic ovf, input logic [7:0] mag);
        int v;
        if (ovf) v = sign ? -256 : 255;
        else     v = sign ? int'(mag) - 256 : int'(mag);
        return v[8:0];
    endfunction

    function automatic logic [8:0] model_sat_add(input logic [8:0] a, input logic [8:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        if (s > 255)  s = 255;
        if (s < -256) s = -256;
        return s[8:0];
    endfunction

    function automatic exp_t model_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        exp_t e;
        e.l = b0[0]; e.r = b0[1]; e.m = b0[2];
        e.x = model_delta(b0[4], b0[6], b1);
        e.y = model_delta(b0[5], b0[7], b2);
        return e;
    endfunction

    // One strobe cycle; returns at the negedge after the sampling edge.
    task automatic drive(input logic [7:0] b, input logic v, input logic e, input logic rd);
        @(negedge clk);
        byte_in = b; byte_valid = v; byte_error = e; mouse_if.read = rd;
        @(negedge clk);
        byte_valid = 1'b0; byte_error = 1'b0; mouse_if.read = 1'b0;
    endtask

    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                               input logic rd_on_last, input logic expect_load);
        drive(b0, 1'b1, 1'b0, 1'b0);
        drive(b1, 1'b1, 1'b0, 1'b0);
        if (expect_load) sb.push_back(model_pkt(b0, b1, b2));
        drive(b2, 1'b1, 1'b0, rd_on_last);
    endtask

    task automatic compare_pop(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_ready"}, 32'(mouse_if.data_ready),    32'd1);
        check({tag, "_left"},  32'(mouse_if.left_button),   32'(e.l));
        check({tag, "_right"}, 32'(mouse_if.right_button),  32'(e.r));
        check({tag, "_mid"},   32'(mouse_if.middle_button), 32'(e.m));
        check({tag, "_x"},     32'(mouse_if.x_increment),   32'(e.x));
        check({tag, "_y"},     32'(mouse_if.y_increment),   32'(e.y));
    endtask

    task automatic do_read(input string tag, input logic exp_ready);
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        check(tag, 32'(mouse_if.data_ready), 32'(exp_ready));
    endtask

    initial begin
        int   waited;
        exp_t acc;
        reset = 1'b1; byte_in = '0; byte_valid = 1'b0; byte_error = 1'b0; mouse_if.read = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(mouse_if.data_ready), 32'd0);
        check("rst_x",     32'(mouse_if.x_increment), 32'd0);
        check("rst_y",     32'(mouse_if.y_increment), 32'd0);
        check("rst_btn",   32'({mouse_if.left_button, mouse_if.right_button, mouse_if.middle_button}), 32'd0);
        check("rst_sync",  32'(sync_error), 32'd0);
        check("rst_ovr",   32'(overrun), 32'd0);
        reset = 1'b0;

        // basic packet, one-cycle latency, read clears
        send_packet(8'h09, 8'h05, 8'hFB, 1'b0, 1'b1);
        compare_pop("t1");
        do_read("t1_read_clr", 1'b0);

        // resync on byte without sync bit
        drive(8'h01, 1'b1, 1'b0, 1'b0);
        check("t2_sync_pulse", 32'(sync_error), 32'd1);
        @(negedge clk);
        check("t2_sync_end", 32'(sync_error), 32'd0);
        send_packet(8'h38, 8'hF0, 8'h10, 1'b0, 1'b1);
        compare_pop("t2");
        do_read("t2_read_clr", 1'b0);

        // overflow saturation
        send_packet(8'h48, 8'h12, 8'h00, 1'b0, 1'b1);
        compare_pop("t3a");
        do_read("t3a_read_clr", 1'b0);
        send_packet(8'h58, 8'h12, 8'h00, 1'b0, 1'b1);
        compare_pop("t3b");
        do_read("t3b_read_clr", 1'b0);

        // inter-byte timeout
        drive(8'h08, 1'b1, 1'b0, 1'b0);
        drive(8'h01, 1'b1, 1'b0, 1'b0);
        waited = 0;
        for (int i = 1; i <= 3 * T; i++) begin
            @(negedge clk);
            if (sync_error) begin waited = i; break; end
        end
        check("t4_timeout_seen", 32'(waited != 0), 32'd1);
        check("t4_timeout_window", 32'(waited >= T - 1 && waited <= T + 1), 32'd1);
        send_packet(8'h08, 8'h02, 8'h03, 1'b0, 1'b1);
        compare_pop("t4");

        // second packet while first unread
`ifdef MOUSE_ACCUMULATE_EN
        send_packet(8'h08, 8'h03, 8'h00, 1'b0, 1'b0);
        check("t5_ovr_tied", 32'(overrun), 32'd0);
        check("t5_x_stable", 32'(mouse_if.x_increment), 32'h002);
        sb.push_back(model_pkt(8'h08, 8'h03, 8'h00));
        do_read("t5_read_keep", 1'b1);
        compare_pop("t5");
        // two overflowed packets accumulate and clamp
        send_packet(8'h48, 8'h00, 8'h00, 1'b0, 1'b0);
        send_packet(8'h49, 8'h10, 8'h00, 1'b0, 1'b0);
        acc = model_pkt(8'h49, 8'h10, 8'h00);
        acc.x = model_sat_add(model_delta(1'b0, 1'b1, 8'h00), model_delta(1'b0, 1'b1, 8'h10));
        acc.y = 9'h000;
        sb.push_back(acc);
        do_read("t5b_read_keep", 1'b1);
        compare_pop("t5b");
        do_read("t5b_read_clr", 1'b0);
`else
        send_packet(8'h08, 8'h03, 8'h00, 1'b0, 1'b0);
        check("t5_ovr_pulse", 32'(overrun), 32'd1);
        check("t5_x_stable", 32'(mouse_if.x_increment), 32'h002);
        check("t5_ready", 32'(mouse_if.data_ready), 32'd1);
        @(negedge clk);
        check("t5_ovr_end", 32'(overrun), 32'd0);
        do_read("t5_read_clr", 1'b0);
`endif

        // byte_error after byte1 discards and returns to WAIT_B0
        drive(8'h08, 1'b1, 1'b0, 1'b0);
        drive(8'h01, 1'b1, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b1, 1'b0);
        check("t6_err_sync", 32'(sync_error), 32'd1);
        drive(8'h05, 1'b1, 1'b0, 1'b0);
        check("t6_b0_resync", 32'(sync_error), 32'd1);
        send_packet(8'h08, 8'h04, 8'h05, 1'b0, 1'b1);
        compare_pop("t6a");
        do_read("t6a_read_clr", 1'b0);

        // byte_error wins over byte_valid
        drive(8'h08, 1'b1, 1'b1, 1'b0);
        check("t6_prio_sync", 32'(sync_error), 32'd1);
        send_packet(8'h09, 8'h06, 8'h07, 1'b0, 1'b1);
        compare_pop("t6b");

        // reset mid-packet with data pending
        drive(8'h08, 1'b1, 1'b0, 1'b0);
        drive(8'h01, 1'b1, 1'b0, 1'b0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check("t6_rst_ready", 32'(mouse_if.data_ready), 32'd0);
        check("t6_rst_x", 32'(mouse_if.x_increment), 32'd0);
        check("t6_rst_btn", 32'(mouse_if.left_button), 32'd0);
        send_packet(8'h0A, 8'h07, 8'h08, 1'b0, 1'b1);
        compare_pop("t6c");

        // read coincident with load keeps data_ready with new values
        send_packet(8'h08, 8'h11, 8'h22, 1'b1, 1'b1);
        compare_pop("t6d");
        do_read("t6d_read_clr", 1'b0);

        // read while idle is ignored
        do_read("t7_idle_read", 1'b0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
